// File: rtl/audio_sample_feeder_if.sv
// ---------------------------------------------------------------------------
// audio_sample_feeder_if
// Sample stream from the synthesizer (ALU / wave generator) into the feeder.
//   sample_in    : unsigned 7-bit sample, midscale 64 (producer -> feeder)
//   sample_valid : sample_in is valid this cycle       (producer -> feeder)
//   sample_ready : feeder can accept a sample          (feeder -> producer)
// A transfer happens on a rising clock edge where valid and ready are both 1.
// ---------------------------------------------------------------------------
interface audio_sample_feeder_if;
  logic [6:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/audio_sample_feeder.sv
// ---------------------------------------------------------------------------
// audio_sample_feeder
// Upstream stage of the codec Audio_Controller. Buffers 7-bit unsigned
// synthesizer samples in a small FIFO, converts each one at pop time to a
// signed, volume-scaled 32-bit PCM word and writes it to both controller
// channels with a one-cycle strobe, only while the controller has space.
//
// Ports:
//   CLOCK_50                : system clock, rising edge
//   reset                   : synchronous, active-high reset
//   smp_bus                 : sample stream (sample_in / sample_valid / sample_ready)
//   volume                  : gain select 0..15, sampled at pop time
//   mute                    : forces the converted word to 0, sampled at pop time
//   audio_out_allowed       : controller output FIFO has space
//   left_channel_audio_out  : signed PCM word, held between writes
//   right_channel_audio_out : same word as the left channel
//   write_audio_out         : one-cycle write strobe to the controller
//   fifo_level              : samples currently buffered
//   underrun_count          : saturating count of underrun events
// ---------------------------------------------------------------------------
module audio_sample_feeder #(
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  audio_sample_feeder_if.slave smp_bus,
  input  logic [3:0]           volume,
  input  logic                 mute,
  input  logic                 audio_out_allowed,
  output logic [31:0]          left_channel_audio_out,
  output logic [31:0]          right_channel_audio_out,
  output logic                 write_audio_out,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [15:0]          underrun_count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Offset-binary to two's complement, then scale by 2^(volume+9).
  // The largest shift is 24, so -64..63 always fits in 32 bits.
  function automatic logic [31:0] pcm_convert(
    input logic [6:0] smp,
    input logic [3:0] vol,
    input logic       mte
  );
    logic [7:0]  s;
    logic [31:0] ext;
    logic [4:0]  sh;
    s   = {1'b0, smp} - 8'd64;
    ext = {{24{s[7]}}, s};
    sh  = {1'b0, vol} + 5'd9;
    if (mte) begin
      return 32'd0;
    end else begin
      return ext << sh;
    end
  endfunction

  state_t           state_r;
  logic [6:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [31:0]      pcm_r;
  logic             wr_r;
  logic [15:0]      ucnt_r;
  logic             under_flag_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic under_s;

  // Handshake and pop/underrun decisions; ready depends on registered level only.
  always_comb begin
    full_s  = (level_r == LVL_W'(DEPTH));
    empty_s = (level_r == {LVL_W{1'b0}});
    push_s  = smp_bus.sample_valid & ~full_s;
    pop_s   = (state_r == IDLE) & audio_out_allowed & ~empty_s;
    under_s = (state_r == IDLE) & audio_out_allowed & empty_s;
  end

  assign smp_bus.sample_ready    = ~full_s;
  assign left_channel_audio_out  = pcm_r;
  assign right_channel_audio_out = pcm_r;
  assign write_audio_out         = wr_r;
  assign fifo_level              = level_r;
  assign underrun_count          = ucnt_r;

  // Sample storage; contents need no reset because pointers define validity.
  always_ff @(posedge CLOCK_50) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= smp_bus.sample_in;
    end
  end

  // FIFO pointers, level, output FSM and underrun counter.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      level_r      <= {LVL_W{1'b0}};
      pcm_r        <= 32'd0;
      wr_r         <= 1'b0;
      ucnt_r       <= 16'd0;
      under_flag_r <= 1'b0;
      state_r      <= IDLE;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end

      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase

      // Count only the rising edge of the underrun condition.
      under_flag_r <= under_s;
      if (under_s && !under_flag_r && (ucnt_r != 16'hFFFF)) begin
        ucnt_r <= ucnt_r + 16'd1;
      end

      // allowed is only looked at in IDLE; WRITE and GAP always run to completion.
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            pcm_r   <= pcm_convert(mem_r[rd_ptr_r], volume, mute);
            wr_r    <= 1'b1;
            state_r <= WRITE;
          end else begin
            wr_r    <= 1'b0;
            state_r <= IDLE;
          end
        end
        WRITE: begin
          wr_r    <= 1'b0;
          state_r <= GAP;
        end
        GAP: begin
          wr_r    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          wr_r    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// ---------------------------------------------------------------------------
// tb_audio_sample_feeder
// Directed vector table, hand-written corner sequences and randomized traffic
// for audio_sample_feeder. A queue-based reference model tracks the expected
// outputs on every clock.
// ---------------------------------------------------------------------------
module tb_audio_sample_feeder;
  localparam int DEPTH = 8;
  localparam int LVL_W = 4;

  logic        CLOCK_50;
  logic        reset;
  logic [3:0]  volume;
  logic        mute;
  logic        audio_out_allowed;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        write_audio_out;
  logic [LVL_W-1:0] fifo_level;
  logic [15:0] underrun_count;

  audio_sample_feeder_if smp_if ();

  audio_sample_feeder #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .smp_bus                 (smp_if),
    .volume                  (volume),
    .mute                    (mute),
    .audio_out_allowed       (audio_out_allowed),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .write_audio_out         (write_audio_out),
    .fifo_level              (fifo_level),
    .underrun_count          (underrun_count)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: buffered samples, cycles until the feeder can pop
  // again, last written word, strobe, underrun count and previous condition.
  int          q[$];
  int          cool    = 0;
  logic [31:0] m_data  = 32'd0;
  bit          m_wr    = 1'b0;
  int          m_ucnt  = 0;
  bit          m_uflag = 1'b0;

  function automatic logic [31:0] ref_pcm(input int smp, input int vol, input bit mt);
    longint v;
    if (mt) return 32'd0;
    v = longint'(smp - 64) * (longint'(1) << (vol + 9));
    return 32'(v);
  endfunction

  // One clock: drive inputs, advance the model, compare DUT with the model.
  task automatic tick(input bit rst, input bit vld, input int smp, input int vol,
                      input bit mt, input bit alw);
    bit push;
    bit pop;
    bit cond;
    reset               = rst;
    smp_if.sample_valid = vld;
    smp_if.sample_in    = 7'(smp);
    volume              = 4'(vol);
    mute                = mt;
    audio_out_allowed   = alw;
    push = vld && (q.size() != DEPTH);
    pop  = (cool == 0) && alw && (q.size() != 0);
    cond = (cool == 0) && alw && (q.size() == 0);
    @(posedge CLOCK_50);
    #1;
    if (rst) begin
      q.delete();
      cool = 0; m_data = 32'd0; m_wr = 1'b0; m_ucnt = 0; m_uflag = 1'b0;
    end else begin
      m_wr = pop;
      if (pop) begin
        m_data = ref_pcm(q.pop_front(), vol, mt);
        cool = 2;
      end else if (cool > 0) begin
        cool--;
      end
      if (push) q.push_back(smp);
      if (cond && !m_uflag && m_ucnt < 65535) m_ucnt++;
      m_uflag = cond;
    end
    n_tests++;
    if (write_audio_out !== m_wr || left_channel_audio_out !== m_data ||
        right_channel_audio_out !== m_data || int'(fifo_level) != q.size() ||
        smp_if.sample_ready !== (q.size() != DEPTH) || int'(underrun_count) != m_ucnt) begin
      n_fail++;
      $display("FAIL model_cycle @%0t: wr=%b exp %b L=%h R=%h exp %h lvl=%0d exp %0d rdy=%b ucnt=%0d exp %0d",
               $time, write_audio_out, m_wr, left_channel_audio_out, right_channel_audio_out,
               m_data, fifo_level, q.size(), smp_if.sample_ready, underrun_count, m_ucnt);
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst, vld;
    int          smp, vol;
    bit          mt, alw;
    bit          e_wr;
    logic [31:0] e_data;
    int          e_lvl;
    bit          e_rdy;
    int          e_ucnt;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int accepts;
    int nstr;
    int str_cyc[$];
    logic [31:0] str_val[$];
    bit spacing_ok;

    reset = 1'b1; smp_if.sample_valid = 1'b0; smp_if.sample_in = 7'd0;
    volume = 4'd0; mute = 1'b0; audio_out_allowed = 1'b0;

    //         rst vld smp vol mt alw  wr  data          lvl rdy ucnt
    tbl[0]  = '{1, 1,  5,  0,  0, 1,   0, 32'h00000000, 0,  1,  0};
    tbl[1]  = '{1, 1,  5,  0,  0, 1,   0, 32'h00000000, 0,  1,  0};
    tbl[2]  = '{1, 1,  5,  0,  0, 1,   0, 32'h00000000, 0,  1,  0};
    tbl[3]  = '{0, 0,  0,  0,  0, 1,   0, 32'h00000000, 0,  1,  1};
    tbl[4]  = '{0, 1,  127,15, 0, 1,   0, 32'h00000000, 1,  1,  1};
    tbl[5]  = '{0, 0,  0,  15, 0, 1,   1, 32'h3F000000, 0,  1,  1};
    tbl[6]  = '{0, 1,  0,  0,  0, 1,   0, 32'h3F000000, 1,  1,  1};
    tbl[7]  = '{0, 0,  0,  0,  0, 1,   0, 32'h3F000000, 1,  1,  1};
    tbl[8]  = '{0, 1,  64, 0,  0, 1,   1, 32'hFFFF8000, 1,  1,  1};
    tbl[9]  = '{0, 0,  0,  0,  0, 1,   0, 32'hFFFF8000, 1,  1,  1};
    tbl[10] = '{0, 0,  0,  0,  0, 1,   0, 32'hFFFF8000, 1,  1,  1};
    tbl[11] = '{0, 0,  0,  0,  0, 1,   1, 32'h00000000, 0,  1,  1};
    tbl[12] = '{0, 0,  0,  0,  0, 1,   0, 32'h00000000, 0,  1,  1};
    tbl[13] = '{0, 0,  0,  0,  0, 1,   0, 32'h00000000, 0,  1,  1};
    tbl[14] = '{0, 0,  0,  0,  0, 1,   0, 32'h00000000, 0,  1,  2};
    tbl[15] = '{0, 1,  100,3,  0, 0,   0, 32'h00000000, 1,  1,  2};
    tbl[16] = '{0, 0,  0,  3,  1, 1,   1, 32'h00000000, 0,  1,  2};
    tbl[17] = '{0, 1,  100,3,  0, 1,   0, 32'h00000000, 1,  1,  2};
    tbl[18] = '{0, 0,  0,  3,  0, 1,   0, 32'h00000000, 1,  1,  2};
    tbl[19] = '{0, 0,  0,  3,  0, 1,   1, 32'h00024000, 0,  1,  2};
    tbl[20] = '{0, 0,  0,  15, 0, 1,   0, 32'h00024000, 0,  1,  2};

    // Directed vectors: reset, conversion/latency, mute, volume change in WRITE.
    for (int i = 0; i < 21; i++) begin
      tick(tbl[i].rst, tbl[i].vld, tbl[i].smp, tbl[i].vol, tbl[i].mt, tbl[i].alw);
      n_tests++;
      if (write_audio_out !== tbl[i].e_wr || left_channel_audio_out !== tbl[i].e_data ||
          right_channel_audio_out !== tbl[i].e_data || int'(fifo_level) != tbl[i].e_lvl ||
          smp_if.sample_ready !== tbl[i].e_rdy || int'(underrun_count) != tbl[i].e_ucnt) begin
        n_fail++;
        $display("FAIL vec%0d: wr=%b/%b L=%h R=%h exp %h lvl=%0d/%0d rdy=%b/%b ucnt=%0d/%0d",
                 i, write_audio_out, tbl[i].e_wr, left_channel_audio_out,
                 right_channel_audio_out, tbl[i].e_data, fifo_level, tbl[i].e_lvl,
                 smp_if.sample_ready, tbl[i].e_rdy, underrun_count, tbl[i].e_ucnt);
      end
    end

    // Full / backpressure: 10 pushes with allowed low, then drain in order.
    tick(1, 0, 0, 15, 0, 0);
    accepts = 0;
    for (int i = 1; i <= 10; i++) begin
      if (smp_if.sample_ready === 1'b1) accepts++;
      tick(0, 1, i, 15, 0, 0);
    end
    check("full_accepts", accepts, 8);
    check("full_level", fifo_level, 8);
    check("full_ready", smp_if.sample_ready, 0);
    for (int c = 0; c < 40; c++) begin
      tick(0, 0, 0, 15, 0, 1);
      if (write_audio_out === 1'b1) begin
        str_cyc.push_back(c);
        str_val.push_back(left_channel_audio_out);
      end
    end
    nstr = str_cyc.size();
    check("drain_strobes", nstr, 8);
    for (int k = 0; k < nstr && k < 8; k++) begin
      check($sformatf("drain_order%0d", k), str_val[k], ref_pcm(k + 1, 15, 0));
    end
    spacing_ok = 1'b1;
    for (int k = 1; k < nstr; k++) begin
      if (str_cyc[k] - str_cyc[k-1] != 3) spacing_ok = 1'b0;
    end
    check("drain_spacing", spacing_ok, 1);
    check("drain_level", fifo_level, 0);

    // Underrun: five rising edges of the condition, then a long steady high.
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0, 0);
    end
    check("underrun_toggle5", underrun_count, 5);
    for (int k = 0; k < 100; k++) tick(0, 0, 0, 0, 0, 1);
    check("underrun_hold", underrun_count, 6);

    // Simultaneous push/pop at level 3, then reset during WRITE.
    tick(1, 0, 0, 5, 0, 0);
    tick(0, 1, 20, 5, 0, 0);
    tick(0, 1, 30, 5, 0, 0);
    tick(0, 1, 40, 5, 0, 0);
    check("level_before_pp", fifo_level, 3);
    tick(0, 1, 50, 5, 0, 1);
    check("level_push_pop", fifo_level, 3);
    check("pp_strobe", write_audio_out, 1);
    check("pp_data", left_channel_audio_out, ref_pcm(20, 5, 0));
    tick(1, 0, 0, 5, 0, 1);
    check("rst_wr_strobe", write_audio_out, 0);
    check("rst_wr_left", left_channel_audio_out, 0);
    check("rst_wr_right", right_channel_audio_out, 0);
    check("rst_wr_level", fifo_level, 0);
    check("rst_wr_ucnt", underrun_count, 0);
    tick(0, 0, 0, 5, 0, 0);
    check("rst_wr_after", write_audio_out, 0);

    // Randomized traffic with phases of different allowed/valid density.
    for (int i = 0; i < 4000; i++) begin
      int ph;
      bit r_rst;
      bit r_vld;
      bit r_alw;
      ph    = (i / 250) % 4;
      r_rst = ($urandom_range(0, 399) == 0);
      r_vld = (ph == 1) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 4);
      r_alw = (ph == 2) ? ($urandom_range(0, 9) < 9) :
              (ph == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
      tick(r_rst, r_vld, $urandom_range(0, 127), $urandom_range(0, 15),
           ($urandom_range(0, 7) == 0), r_alw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
